hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller_pkg.sv | 19 +
 rtl/hazard_ld_use_detect.sv | 27 ++
 rtl/hazard_controller.sv | 175 +++++++++++++++++
 tb/tb_hazard_controller.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_controller_pkg.sv
// ---------------------------------------------------------------------------
// hazard_controller_pkg
// Shared types and constants for the pipeline hazard controller.
//   hz_state_e       : controller FSM state encoding
//   XZR_REG          : zero register, never a real data dependency
//   FLUSH_CYCLES_DEF : default IF/ID flush length after a taken branch
// ---------------------------------------------------------------------------
package hazard_controller_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_FLUSH    = 2'd2
   } hz_state_e;

   localparam logic [4:0] XZR_REG          = 5'd31;
   localparam int         FLUSH_CYCLES_DEF = 1;

endpackage

// File: rtl/hazard_ld_use_detect.sv
// ---------------------------------------------------------------------------
// hazard_ld_use_detect
// Combinational load-use detector: a load in EX whose destination is read by
// the instruction in ID. Writes to the zero register never create a hazard.
// Ports:
//   mem_read : EX instruction is a load
//   rd_ex    : EX destination register
//   rn_id    : ID first source register
//   rm_id    : ID second source register
//   ld_use   : load-use hazard present
// ---------------------------------------------------------------------------
module hazard_ld_use_detect
   import hazard_controller_pkg::*;
(
   input  logic       mem_read,
   input  logic [4:0] rd_ex,
   input  logic [4:0] rn_id,
   input  logic [4:0] rm_id,
   output logic       ld_use
);

   always_comb begin
      ld_use = mem_read && (rd_ex != XZR_REG) &&
               ((rd_ex == rn_id) || (rd_ex == rm_id));
   end

endmodule

// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
// Pipeline hazard controller: load-use bubbles, data-memory wait holds and
// IF/ID flushing after taken branches.
// Parameters:
//   FLUSH_CYCLES : cycles IF/ID flush is held after a taken branch (1..7)
//   CNT_W        : width of the optional stall counter
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   MemRead_EX          : EX instruction is a load
//   RegRd_EX            : EX destination register
//   RegRn_ID, RegRm_ID  : ID source registers
//   BrTaken             : branch resolved taken this cycle
//   mem_req, mem_ready  : data memory access / completion in MEM
//   PCWrite, IFIDWrite  : PC and IF/ID write enables
//   pipe_hold           : freezes ID/EX, EX/MEM, MEM/WB
//   IDEXBubble          : zeroes ID/EX control fields
//   IFIDFlush           : clears IF/ID to a NOP
//   state_o             : current FSM state
//   stall_cnt           : cycles with PCWrite=0, saturating
//                         (only with HAZARD_STALL_COUNT_EN defined)
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_RUN      | normal flow; load-use bubbles inserted combinationally
// ST_MEM_WAIT | data memory busy; front end and back end frozen
// ST_FLUSH    | squashing wrong-path fetches after a taken branch
// (3)         | illegal; recovers to ST_RUN on the next clock
// ---------------------------------------------------------------------------
module hazard_controller
   import hazard_controller_pkg::*;
#(
   parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             MemRead_EX,
   input  logic [4:0]       RegRd_EX,
   input  logic [4:0]       RegRn_ID,
   input  logic [4:0]       RegRm_ID,
   input  logic             BrTaken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             pipe_hold,
   output logic             IDEXBubble,
   output logic             IFIDFlush,
   output logic [1:0]       state_o
`ifdef HAZARD_STALL_COUNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt
`endif
);

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

   hz_state_e  state, state_nxt;
   logic [2:0] flush_cnt, flush_cnt_nxt;
   logic       pend_flush, pend_flush_nxt;
   logic       ld_use;
   logic       mem_miss;

   // A same-cycle ready is a zero-wait access.
   assign mem_miss = mem_req && !mem_ready;

   hazard_ld_use_detect u_ld_use (
      .mem_read (MemRead_EX),
      .rd_ex    (RegRd_EX),
      .rn_id    (RegRn_ID),
      .rm_id    (RegRm_ID),
      .ld_use   (ld_use)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_RUN;
         flush_cnt  <= 3'd0;
         pend_flush <= 1'b0;
      end else begin
         state      <= state_nxt;
         flush_cnt  <= flush_cnt_nxt;
         pend_flush <= pend_flush_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      flush_cnt_nxt  = flush_cnt;
      pend_flush_nxt = pend_flush;
      case (state)
         ST_RUN: begin
            if (mem_miss) begin
               state_nxt = ST_MEM_WAIT;
            end else if (BrTaken) begin
               state_nxt      = ST_FLUSH;
               flush_cnt_nxt  = FLUSH_LOAD;
               pend_flush_nxt = 1'b0;
            end
         end
         ST_MEM_WAIT: begin
            if (BrTaken)
               pend_flush_nxt = 1'b1;
            if (mem_ready) begin
               // A branch arriving on the release cycle still owes a flush.
               if (pend_flush || BrTaken) begin
                  state_nxt      = ST_FLUSH;
                  flush_cnt_nxt  = FLUSH_LOAD;
                  pend_flush_nxt = 1'b0;
               end else begin
                  state_nxt = ST_RUN;
               end
            end
         end
         ST_FLUSH: begin
            if (flush_cnt <= 3'd1) begin
               state_nxt     = ST_RUN;
               flush_cnt_nxt = 3'd0;
            end else begin
               flush_cnt_nxt = flush_cnt - 3'd1;
            end
         end
         default: begin
            state_nxt      = ST_RUN;
            flush_cnt_nxt  = 3'd0;
            pend_flush_nxt = 1'b0;
         end
      endcase
   end

   always_comb begin
      PCWrite    = 1'b1;
      IFIDWrite  = 1'b1;
      pipe_hold  = 1'b0;
      IDEXBubble = 1'b0;
      IFIDFlush  = 1'b0;
      state_o    = ST_RUN;
      if (!reset) begin
         state_o = state;
         case (state)
            ST_RUN: begin
               // Memory miss and branch outrank the load-use bubble.
               if (!mem_miss && !BrTaken && ld_use) begin
                  PCWrite    = 1'b0;
                  IFIDWrite  = 1'b0;
                  IDEXBubble = 1'b1;
               end
            end
            ST_MEM_WAIT: begin
               PCWrite   = 1'b0;
               IFIDWrite = 1'b0;
               pipe_hold = 1'b1;
            end
            ST_FLUSH: begin
               IFIDFlush  = 1'b1;
               IDEXBubble = 1'b1;
            end
            default: begin
               state_o = ST_RUN;
            end
         endcase
      end
   end

`ifdef HAZARD_STALL_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset)
         stall_cnt <= '0;
      else if (!PCWrite && (stall_cnt != {CNT_W{1'b1}}))
         stall_cnt <= stall_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_hazard_controller
// Self-checking bench for hazard_controller. A behavioural model tracks
// "waiting on memory", "flush cycles left" and "branch owed" and predicts
// every output each cycle. Optional stall counter checked when
// HAZARD_STALL_COUNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_hazard_controller;

   localparam int FC = 3;
   localparam int CW = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       MemRead_EX;
   logic [4:0] RegRd_EX, RegRn_ID, RegRm_ID;
   logic       BrTaken, mem_req, mem_ready;
   logic       PCWrite, IFIDWrite, pipe_hold, IDEXBubble, IFIDFlush;
   logic [1:0] state_o;
`ifdef HAZARD_STALL_COUNT_EN
   logic [CW-1:0] stall_cnt;
`endif

   always #5 clk = ~clk;

   hazard_controller #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .MemRead_EX (MemRead_EX),
      .RegRd_EX   (RegRd_EX),
      .RegRn_ID   (RegRn_ID),
      .RegRm_ID   (RegRm_ID),
      .BrTaken    (BrTaken),
      .mem_req    (mem_req),
      .mem_ready  (mem_ready),
      .PCWrite    (PCWrite),
      .IFIDWrite  (IFIDWrite),
      .pipe_hold  (pipe_hold),
      .IDEXBubble (IDEXBubble),
      .IFIDFlush  (IFIDFlush),
      .state_o    (state_o)
`ifdef HAZARD_STALL_COUNT_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   int n_vec = 0;
   int n_mis = 0;
   int cyc   = 0;

   // model
   bit m_wait      = 0;
   int m_flush_left = 0;
   bit m_owed      = 0;
   int m_stalls    = 0;

   // observed values from the last sampled cycle
   bit seen_hold, seen_flush;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic drive(input bit rst, input bit mr, input int rd, input int rn,
                        input int rm, input bit br, input bit rq, input bit rdy);
      reset      = rst;
      MemRead_EX = mr;
      RegRd_EX   = 5'(rd);
      RegRn_ID   = 5'(rn);
      RegRm_ID   = 5'(rm);
      BrTaken    = br;
      mem_req    = rq;
      mem_ready  = rdy;
   endtask

   task automatic step();
      bit miss, ldu;
      bit e_pcw, e_ifw, e_hold, e_bub, e_fl;
      int e_st;
      @(negedge clk);
      miss = mem_req && !mem_ready;
      ldu  = MemRead_EX && (RegRd_EX != 5'd31) &&
             (RegRd_EX == RegRn_ID || RegRd_EX == RegRm_ID);
      e_pcw = 1; e_ifw = 1; e_hold = 0; e_bub = 0; e_fl = 0; e_st = 0;
      if (!reset) begin
         if (m_flush_left > 0) begin
            e_st = 2; e_fl = 1; e_bub = 1;
         end else if (m_wait) begin
            e_st = 1; e_pcw = 0; e_ifw = 0; e_hold = 1;
         end else if (!miss && !BrTaken && ldu) begin
            e_pcw = 0; e_ifw = 0; e_bub = 1;
         end
      end
      check("PCWrite",    32'(PCWrite),    32'(e_pcw));
      check("IFIDWrite",  32'(IFIDWrite),  32'(e_ifw));
      check("pipe_hold",  32'(pipe_hold),  32'(e_hold));
      check("IDEXBubble", 32'(IDEXBubble), 32'(e_bub));
      check("IFIDFlush",  32'(IFIDFlush),  32'(e_fl));
      check("state_o",    32'(state_o),    32'(e_st));
`ifdef HAZARD_STALL_COUNT_EN
      check("stall_cnt",  32'(stall_cnt),  32'(m_stalls));
`endif
      seen_hold  = pipe_hold;
      seen_flush = IFIDFlush;
      @(posedge clk);
      if (reset) begin
         m_wait = 0; m_flush_left = 0; m_owed = 0; m_stalls = 0;
      end else begin
         if (!e_pcw && m_stalls < (1 << CW) - 1)
            m_stalls++;
         if (m_flush_left > 0) begin
            m_flush_left--;
         end else if (m_wait) begin
            if (BrTaken) m_owed = 1;
            if (mem_ready) begin
               m_wait = 0;
               if (m_owed) begin
                  m_flush_left = FC;
                  m_owed = 0;
               end
            end
         end else if (miss) begin
            m_wait = 1;
         end else if (BrTaken) begin
            m_flush_left = FC;
         end
      end
      cyc++;
      #1;
   endtask

   function automatic int pick_reg();
      int r = $urandom_range(0, 9);
      return (r > 7) ? 31 : r;
   endfunction

   initial begin
      int cnt;
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      step(); step();

      // load-use: one bubble, then flow resumes
      drive(0, 1, 5, 5, 1, 0, 0, 0); step();
      check("ldu_pcw_low", 32'(PCWrite), 32'd0);
      drive(0, 0, 5, 5, 1, 0, 0, 0); step();

      // zero register is never a dependency
      drive(0, 1, 31, 2, 31, 0, 0, 0); step();

      // three cycles of memory not ready
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 1, 2, 0, 1, 0); step();
         cnt += int'(seen_hold);
      end
      drive(0, 0, 0, 1, 2, 0, 1, 1); step();
      cnt += int'(seen_hold);
      check("mem_hold_cycles", 32'(cnt), 32'd3);
      drive(0, 0, 0, 1, 2, 0, 0, 0); step();
      check("mem_hold_release", 32'(pipe_hold), 32'd0);

      // branch during memory wait flushes after release
      drive(0, 0, 0, 1, 2, 0, 1, 0); step();
      drive(0, 0, 0, 1, 2, 1, 1, 0); step();
      drive(0, 0, 0, 1, 2, 0, 1, 0); step();
      drive(0, 0, 0, 1, 2, 0, 1, 1); step();
      cnt = 0;
      for (int i = 0; i < FC + 2; i++) begin
         drive(0, 0, 0, 1, 2, 0, 0, 0); step();
         cnt += int'(seen_flush);
      end
      check("flush_cycles", 32'(cnt), 32'(FC));

      // branch and load-use together: branch wins, no stall
      drive(0, 1, 7, 3, 7, 1, 0, 0); step();
      check("br_ldu_pcw", 32'(PCWrite), 32'd1);
      for (int i = 0; i < FC + 1; i++) begin
         drive(0, 1, 7, 3, 7, 0, 0, 0); step();
      end

      // reset mid memory wait drops the owed branch
      drive(0, 0, 0, 1, 2, 0, 1, 0); step();
      drive(0, 0, 0, 1, 2, 1, 1, 0); step();
      drive(1, 0, 0, 1, 2, 0, 1, 0); step();
      drive(0, 0, 0, 1, 2, 0, 0, 1); step();
      check("rst_wait_state", 32'(state_o), 32'd0);
      drive(0, 0, 0, 1, 2, 0, 0, 0); step();
      check("rst_no_flush", 32'(IFIDFlush), 32'd0);

      // long wait drives the counter into saturation
      for (int i = 0; i < 20; i++) begin
         drive(0, 0, 0, 1, 2, 0, 1, 0); step();
      end
      drive(0, 0, 0, 1, 2, 0, 1, 1); step();
      drive(0, 0, 0, 1, 2, 0, 0, 0); step();

      // reset mid flush
      drive(0, 0, 0, 1, 2, 1, 0, 0); step();
      drive(0, 0, 0, 1, 2, 0, 0, 0); step();
      drive(1, 0, 0, 1, 2, 0, 0, 0); step();
      drive(0, 0, 0, 1, 2, 0, 0, 0); step();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 99) < 2), $urandom_range(0, 1), pick_reg(),
               pick_reg(), pick_reg(), ($urandom_range(0, 99) < 15),
               ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 55));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
